// File: rtl/muldiv_pkg.sv
// Shared types for the multi-cycle multiply/divide unit: operation and
// FSM state encodings plus small helpers for classifying an operation.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL  = 3'd0,
        MD_MULU = 3'd1,
        MD_DIV  = 3'd2,
        MD_DIVU = 3'd3,
        MD_MOD  = 3'd4,
        MD_MODU = 3'd5
    } Muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } Muldiv_state_t;

    // Divide-class ops (quotient or remainder) run the restoring datapath.
    function automatic logic op_is_div(input Muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_MOD) || (op == MD_MODU);
    endfunction

    // Remainder-selecting ops.
    function automatic logic op_is_mod(input Muldiv_op_t op);
        return (op == MD_MOD) || (op == MD_MODU);
    endfunction

    // Ops whose operands are two's complement and need magnitude/sign handling.
    function automatic logic op_is_signed(input Muldiv_op_t op);
        return (op == MD_MUL) || (op == MD_DIV) || (op == MD_MOD);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative datapath, purely combinational.
// Multiply: acc accumulates, x is the multiplicand (shifts left), y the
// multiplier (shifts right). Divide: acc is the partial remainder, x the
// divisor, y holds the dividend bits shifting out MSB first while quotient
// bits shift in at the bottom.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 16
) (
    input  Muldiv_op_t        op,
    input  logic [XLEN:0]     acc,
    input  logic [XLEN-1:0]   x,
    input  logic [XLEN-1:0]   y,
    output logic [XLEN:0]     acc_next,
    output logic [XLEN-1:0]   x_next,
    output logic [XLEN-1:0]   y_next
);

    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] trial;
    logic [XLEN:0]   addend;

    // Compute either a shift-add step or a restoring-divide step.
    always_comb begin
        shifted  = {acc[XLEN-1:0], y[XLEN-1]};
        trial    = {1'b0, shifted} - {2'b00, x};
        addend   = y[0] ? {1'b0, x} : '0;
        acc_next = acc;
        x_next   = x;
        y_next   = y;
        if (op_is_div(op)) begin
            // A non-negative trial difference means the divisor fits: keep it.
            if (!trial[XLEN+1]) begin
                acc_next = trial[XLEN:0];
                y_next   = {y[XLEN-2:0], 1'b1};
            end else begin
                acc_next = shifted;
                y_next   = {y[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next = acc + addend;
            x_next   = {x[XLEN-2:0], 1'b0};
            y_next   = {1'b0, y[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle integer multiply/divide unit. Accepts one op at a time through
// a valid/ready handshake, iterates XLEN steps of muldiv_step, then holds the
// result as a CDB request until granted. Recovery aborts in any state.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 16,
    parameter int ROB_W = 5,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             recovery_en,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  Muldiv_op_t       issue_op,
    input  logic [XLEN-1:0]  issue_a,
    input  logic [XLEN-1:0]  issue_b,
    input  logic [ROB_W-1:0] issue_rob,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             cdb_valid,
    input  logic             cdb_gnt,
    output logic [XLEN-1:0]  cdb_result,
    output logic             cdb_exc,
    output logic [ROB_W-1:0] cdb_rob,
    output logic [TAG_W-1:0] cdb_tag
);

    localparam int CNT_W = (XLEN > 2) ? $clog2(XLEN) : 1;

    Muldiv_state_t    state_reg, state_next;
    Muldiv_op_t       op_reg;
    logic             sign_reg;
    logic [CNT_W-1:0] count_reg;
    logic [XLEN:0]    acc_reg;
    logic [XLEN-1:0]  x_reg, y_reg;
    logic [XLEN-1:0]  result_reg;
    logic             exc_reg;
    logic [ROB_W-1:0] rob_reg;
    logic [TAG_W-1:0] tag_reg;

    logic             accept;
    logic             a_neg, b_neg, div_zero;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic [XLEN:0]    acc_next;
    logic [XLEN-1:0]  x_next, y_next;
    logic [XLEN-1:0]  mag_result, final_result;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .op       (op_reg),
        .acc      (acc_reg),
        .x        (x_reg),
        .y        (y_reg),
        .acc_next (acc_next),
        .x_next   (x_next),
        .y_next   (y_next)
    );

    // Issue-side decode: magnitudes, divide-by-zero detect, accept condition.
    always_comb begin
        accept   = issue_valid && (state_reg == IDLE) && !recovery_en;
        a_neg    = op_is_signed(issue_op) && issue_a[XLEN-1];
        b_neg    = op_is_signed(issue_op) && issue_b[XLEN-1];
        a_mag    = a_neg ? (~issue_a + 1'b1) : issue_a;
        b_mag    = b_neg ? (~issue_b + 1'b1) : issue_b;
        div_zero = op_is_div(issue_op) && (issue_b == '0);
    end

    // Result selection and sign fix-up for the final iteration.
    always_comb begin
        if (op_is_div(op_reg) && !op_is_mod(op_reg)) begin
            mag_result = y_next;
        end else begin
            mag_result = acc_next[XLEN-1:0];
        end
        final_result = sign_reg ? (~mag_result + 1'b1) : mag_result;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; recovery overrides everything.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = div_zero ? DONE : CALC;
            CALC: if (count_reg == '0) state_next = DONE;
            DONE: if (cdb_gnt) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (recovery_en) state_next = IDLE;
    end

    // Handshake outputs depend on state only (plus the recovery squash).
    always_comb begin
        issue_ready = (state_reg == IDLE);
        cdb_valid   = (state_reg == DONE) && !recovery_en;
    end

    // Datapath, counter and held CDB payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg     <= MD_MUL;
            sign_reg   <= 1'b0;
            count_reg  <= '0;
            acc_reg    <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            result_reg <= '0;
            exc_reg    <= 1'b0;
            rob_reg    <= '0;
            tag_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg    <= issue_op;
                        rob_reg   <= issue_rob;
                        tag_reg   <= issue_tag;
                        sign_reg  <= op_is_mod(issue_op) ? a_neg : (a_neg ^ b_neg);
                        count_reg <= CNT_W'(XLEN - 1);
                        acc_reg   <= '0;
                        // Divide keeps the divisor in x and shifts the dividend out of y.
                        x_reg     <= op_is_div(issue_op) ? b_mag : a_mag;
                        y_reg     <= op_is_div(issue_op) ? a_mag : b_mag;
                        if (div_zero) begin
                            result_reg <= '0;
                            exc_reg    <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    acc_reg   <= acc_next;
                    x_reg     <= x_next;
                    y_reg     <= y_next;
                    count_reg <= count_reg - CNT_W'(1);
                    if (count_reg == '0 && !recovery_en) begin
                        result_reg <= final_result;
                        exc_reg    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cdb_result = result_reg;
    assign cdb_exc    = exc_reg;
    assign cdb_rob    = rob_reg;
    assign cdb_tag    = tag_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed, table-driven bench for muldiv_seq with hand-computed results,
// plus hand-written sequences for grant stall, recovery and reset corners.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int XLEN  = 16;
    localparam int ROB_W = 5;
    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             recovery_en;
    logic             issue_valid;
    logic             issue_ready;
    Muldiv_op_t       issue_op;
    logic [XLEN-1:0]  issue_a, issue_b;
    logic [ROB_W-1:0] issue_rob;
    logic [TAG_W-1:0] issue_tag;
    logic             cdb_valid;
    logic             cdb_gnt;
    logic [XLEN-1:0]  cdb_result;
    logic             cdb_exc;
    logic [ROB_W-1:0] cdb_rob;
    logic [TAG_W-1:0] cdb_tag;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_seq #(.XLEN(XLEN), .ROB_W(ROB_W), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .recovery_en (recovery_en),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_a     (issue_a),
        .issue_b     (issue_b),
        .issue_rob   (issue_rob),
        .issue_tag   (issue_tag),
        .cdb_valid   (cdb_valid),
        .cdb_gnt     (cdb_gnt),
        .cdb_result  (cdb_result),
        .cdb_exc     (cdb_exc),
        .cdb_rob     (cdb_rob),
        .cdb_tag     (cdb_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        Muldiv_op_t  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present one op at a negedge; it is accepted on the following posedge.
    task automatic do_issue(input Muldiv_op_t op, input logic [15:0] a, input logic [15:0] b,
                            input logic [ROB_W-1:0] rob, input logic [TAG_W-1:0] tag);
        @(negedge clk);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_a     = a;
        issue_b     = b;
        issue_rob   = rob;
        issue_tag   = tag;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until cdb_valid is seen (bounded).
    task automatic wait_valid(output int edges);
        edges = 0;
        while (cdb_valid !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic grant();
        @(negedge clk);
        cdb_gnt = 1'b1;
        @(posedge clk);
        #1;
        cdb_gnt = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        logic [15:0] held;

        vecs[0]  = '{MD_MULU, 16'd300,   16'd200,   16'hEA60, 1'b0};
        vecs[1]  = '{MD_MUL,  16'hFFFD,  16'd7,     16'hFFEB, 1'b0};
        vecs[2]  = '{MD_MUL,  16'h8000,  16'hFFFF,  16'h8000, 1'b0};
        vecs[3]  = '{MD_DIV,  16'hFFF9,  16'd2,     16'hFFFD, 1'b0};
        vecs[4]  = '{MD_MOD,  16'hFFF9,  16'd2,     16'hFFFF, 1'b0};
        vecs[5]  = '{MD_DIVU, 16'hFFFF,  16'd3,     16'h5555, 1'b0};
        vecs[6]  = '{MD_DIV,  16'h8000,  16'hFFFF,  16'h8000, 1'b0};
        vecs[7]  = '{MD_DIV,  16'd5,     16'd0,     16'h0000, 1'b1};
        vecs[8]  = '{MD_MUL,  16'd3,     16'd5,     16'h000F, 1'b0};
        vecs[9]  = '{MD_MODU, 16'd100,   16'd7,     16'h0002, 1'b0};
        vecs[10] = '{MD_DIVU, 16'd100,   16'd7,     16'h000E, 1'b0};
        vecs[11] = '{MD_MOD,  16'd7,     16'hFFFE,  16'h0001, 1'b0};
        vecs[12] = '{MD_DIV,  16'd7,     16'hFFFE,  16'hFFFD, 1'b0};
        vecs[13] = '{MD_MODU, 16'd5,     16'd0,     16'h0000, 1'b1};

        rst = 1'b1; recovery_en = 1'b0; issue_valid = 1'b0; cdb_gnt = 1'b0;
        issue_op = MD_MUL; issue_a = '0; issue_b = '0; issue_rob = '0; issue_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("reset_ready",  issue_ready, 1);
        chk("reset_valid",  cdb_valid,   0);
        chk("reset_result", cdb_result,  0);
        chk("reset_exc",    cdb_exc,     0);
        chk("reset_rob",    cdb_rob,     0);
        chk("reset_tag",    cdb_tag,     0);

        for (int i = 0; i < 14; i++) begin
            do_issue(vecs[i].op, vecs[i].a, vecs[i].b, ROB_W'(i + 1), TAG_W'(i + 10));
            chk("busy_ready", issue_ready, 0);
            wait_valid(lat);
            // Cycle index counts the cycle right after the accept edge as 1.
            chk("latency", lat + 1, vecs[i].exc ? 1 : XLEN + 1);
            chk("result", cdb_result, vecs[i].res);
            chk("exc",    cdb_exc,    vecs[i].exc);
            chk("rob",    cdb_rob,    ROB_W'(i + 1));
            chk("tag",    cdb_tag,    TAG_W'(i + 10));
            $display("vec %0d op=%0d a=%h b=%h -> result=%h exc=%b cycles=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, cdb_result, cdb_exc, lat + 1);
            grant();
            chk("post_gnt_ready", issue_ready, 1);
            chk("post_gnt_valid", cdb_valid,   0);
        end

        // Grant withheld for three cycles: payload must hold steady.
        do_issue(MD_MULU, 16'h0102, 16'h0003, 5'd7, 6'd21);
        wait_valid(lat);
        held = cdb_result;
        chk("stall_result0", held, 16'h0306);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall_valid",  cdb_valid,  1);
            chk("stall_ready",  issue_ready, 0);
            chk("stall_result", cdb_result, held);
            chk("stall_rob",    cdb_rob,    7);
        end
        grant();
        chk("stall_gnt_ready", issue_ready, 1);
        $display("stall seq result=%h ready_after_gnt=%b", held, issue_ready);

        // Recovery five cycles into CALC: op must never complete.
        do_issue(MD_MUL, 16'd9, 16'd9, 5'd3, 6'd4);
        repeat (4) @(posedge clk);
        @(negedge clk);
        recovery_en = 1'b1;
        @(posedge clk);
        #1;
        recovery_en = 1'b0;
        chk("rec_calc_ready", issue_ready, 1);
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (cdb_valid === 1'b1) seen = 1;
        end
        chk("rec_calc_no_valid", seen, 0);
        $display("recovery in CALC ready=%b valid_seen=%0d", issue_ready, seen);

        // Recovery coincident with an issue: not accepted.
        @(negedge clk);
        issue_valid = 1'b1; recovery_en = 1'b1;
        issue_op = MD_MULU; issue_a = 16'd2; issue_b = 16'd2;
        @(posedge clk);
        #1;
        issue_valid = 1'b0; recovery_en = 1'b0;
        chk("rec_issue_ready", issue_ready, 1);
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (cdb_valid === 1'b1) seen = 1;
        end
        chk("rec_issue_no_valid", seen, 0);
        $display("recovery with issue ready=%b valid_seen=%0d", issue_ready, seen);

        // Recovery coincident with grant in DONE: valid squashed that cycle.
        do_issue(MD_DIVU, 16'd100, 16'd7, 5'd12, 6'd40);
        wait_valid(lat);
        chk("rec_gnt_pre_valid", cdb_valid, 1);
        @(negedge clk);
        cdb_gnt = 1'b1; recovery_en = 1'b1;
        #1;
        chk("rec_gnt_valid", cdb_valid, 0);
        @(posedge clk);
        #1;
        cdb_gnt = 1'b0; recovery_en = 1'b0;
        chk("rec_gnt_ready", issue_ready, 1);
        chk("rec_gnt_valid_after", cdb_valid, 0);
        $display("recovery with grant ready=%b valid=%b", issue_ready, cdb_valid);

        // Reset in the middle of CALC.
        do_issue(MD_MUL, 16'h0011, 16'h0022, 5'd9, 6'd33);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_calc_ready",  issue_ready, 1);
        chk("rst_calc_valid",  cdb_valid,   0);
        chk("rst_calc_result", cdb_result,  0);
        chk("rst_calc_exc",    cdb_exc,     0);
        chk("rst_calc_rob",    cdb_rob,     0);
        chk("rst_calc_tag",    cdb_tag,     0);
        @(negedge clk);
        rst = 1'b0;
        $display("reset mid-CALC ready=%b valid=%b result=%h", issue_ready, cdb_valid, cdb_result);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle integer multiply/divide unit that takes MUL/DIV/MOD operations (and their unsigned forms) off the single-cycle integer ALU. It sits beside `int_alu` on the issue side and takes one operation at a time through a valid/ready handshake. It sequences an iterative shift-add / restoring-divide datapath over XLEN cycles. Completed results are held on a CDB request until the CDB arbiter grants them, and the unit aborts immediately on branch-mispredict recovery.

## Interface
- `XLEN`, default 16: operand and result width.
- `ROB_W`, default 5: ROB index width.
- `TAG_W`, default 6: physical register tag width.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `recovery_en` in 1: flush. Abort the in-flight operation and drop any issue in the same cycle.
- `issue_valid` in 1: issue request.
- `issue_ready` out 1: unit can accept. High only in IDLE.
- `issue_op` in 3: `Muldiv_op_t`, one of MD_MUL, MD_MULU, MD_DIV, MD_DIVU, MD_MOD, MD_MODU.
- `issue_a` in XLEN: operand A (multiplicand / dividend).
- `issue_b` in XLEN: operand B, already immediate-muxed (multiplier / divisor).
- `issue_rob` in ROB_W: ROB index.
- `issue_tag` in TAG_W: destination physical tag.
- `cdb_valid` out 1: result ready for broadcast.
- `cdb_gnt` in 1: CDB arbiter grant. Broadcast completes when `cdb_valid && cdb_gnt`.
- `cdb_result` out XLEN: result value.
- `cdb_exc` out 1: exception flag (divide by zero).
- `cdb_rob` out ROB_W: ROB index of the held operation.
- `cdb_tag` out TAG_W: destination tag of the held operation.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE.** An accept occurs when `issue_valid && issue_ready && !recovery_en`. On accept, latch op, rob and tag.
  - Signed ops: latch |a| and |b| and record the result sign.
    - MUL and DIV: sign = sign(a) XOR sign(b).
    - MOD: sign = sign(a).
  - Unsigned ops: operands are used as-is.
- **Divide by zero.** A DIV/DIVU/MOD/MODU with b==0 goes directly to DONE with result 0 and `cdb_exc`=1.
- **Other ops** go to CALC with `count` = XLEN-1.
- **CALC, multiply.** Each cycle: if the multiplier LSB is 1, add the multiplicand into the accumulator; shift the multiplicand left and the multiplier right.
  - Product is the low XLEN bits, modulo 2^XLEN.
  - Signed result = 2's complement negation of the magnitude product when sign=1.
- **CALC, divide.** Restoring division, one quotient bit per cycle, MSB first. Remainder is XLEN+1 bits wide.
  - Quotient sign = recorded sign. Remainder sign follows the dividend (truncating division).
  - -2^(XLEN-1) / -1 gives quotient 0x8000 (wraps), remainder 0, no exception.
- **CALC exit.** When `count`==0, apply the sign fix-up, select quotient (DIV/DIVU) or remainder (MOD/MODU), and go to DONE.
- **DONE.** `cdb_valid`=1 and all cdb_* outputs are held stable until grant. On `cdb_gnt`, go to IDLE.
- **Recovery.**
  - `recovery_en` in any state forces IDLE on the next edge.
  - `cdb_valid` is forced to 0 combinationally in the same cycle, so a grant in that cycle is ignored.
  - An issue in the same cycle is not accepted.
- **Reset values.** `issue_ready`=1 (IDLE); `cdb_valid`=0; `cdb_result`, `cdb_exc`, `cdb_rob`, `cdb_tag` = 0.

## Timing
- Accept at edge t.
- Normal ops: CALC during cycles t+1 … t+XLEN; `cdb_valid` first high in cycle t+XLEN+1, which is 17 cycles for XLEN=16.
- Divide by zero: `cdb_valid` high in cycle t+1.
- DONE → IDLE on the edge where the grant occurs.
- `issue_ready` rises the cycle after grant; there is no same-cycle re-issue, so back-to-back throughput is one op per XLEN+2 cycles.
- `issue_ready` is a function of state only and never depends on `issue_valid`.
- Recovery in cycle c: `issue_ready`=1 in cycle c+1.

## Structure
- Shared package: `Muldiv_op_t` enum, `Muldiv_state_t` enum (IDLE/CALC/DONE), `MD_*` encodings.
- Sub-module `muldiv_step`, combinational. Given the op class and the current accumulator/remainder, multiplicand/divisor and multiplier/quotient, it produces the next values for one iteration.
- The FSM, counter, sign handling and output registers stay in `muldiv_seq`.

## Test plan
- MULU 300 × 200 → `cdb_result`=0xEA60, `cdb_exc`=0, `cdb_valid` exactly 17 cycles after accept, rob/tag echoed.
- MUL 0xFFFD × 7 → 0xFFEB (-21); MUL 0x8000 × 0xFFFF → 0x8000.
- DIV 0xFFF9 / 2 → 0xFFFD (-3); MOD 0xFFF9 % 2 → 0xFFFF (-1); DIVU 0xFFFF / 3 → 0x5555; DIV 0x8000 / 0xFFFF → 0x8000, exc 0.
- DIV 5 / 0 → `cdb_valid` at t+1, result 0, `cdb_exc`=1; subsequent MUL completes normally.
- `cdb_gnt` held low 3 cycles in DONE → outputs stable and `issue_ready`=0 throughout; grant → `issue_ready`=1 next cycle.
- `recovery_en` pulsed 5 cycles into CALC → no `cdb_valid` ever for that op, `issue_ready`=1 next cycle.
- `recovery_en` coincident with `issue_valid` → not accepted.
- `recovery_en` coincident with grant in DONE → `cdb_valid`=0 that cycle.
- `rst` mid-CALC → reset values next cycle.
